// File: rtl/serial_add_sub_pkg.sv
// Shared constants and controller state encoding for the bit-serial adder/subtractor.
package serial_add_sub_pkg;

   localparam int DATA_WIDTH = 32;

   typedef enum logic [1:0] {
      SAS_IDLE   = 2'b00,
      SAS_RUN    = 2'b01,
      SAS_FINISH = 2'b10
   } sas_state_t;

endpackage

// File: rtl/serial_add_sub_full_adder_1b.sv
// Combinational one-bit full adder; the only arithmetic cell of the serial datapath.
module full_adder_1b (
   input  logic A,
   input  logic B,
   input  logic CI,
   output logic S,
   output logic CO
);

   assign S  = A ^ B ^ CI;
   assign CO = (A & B) | (A & CI) | (B & CI);

endmodule

// File: rtl/serial_add_sub.sv
// Bit-serial add/subtract, LSB first, one full-adder cell plus a carry flop.
// Results and flags are published in a single FINISH cycle alongside a DONE pulse.
module serial_add_sub
   import serial_add_sub_pkg::*;
#(
   parameter int WIDTH = DATA_WIDTH,
   parameter int CNT_W = 6
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             START,
   input  logic             SUB,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic [WIDTH-1:0] Y,
   output logic             CO,
   output logic             V,
   output logic             Z,
   output logic             BUSY,
   output logic             DONE
);

   sas_state_t       r_state;
   logic [WIDTH-1:0] r_op_a;
   logic [WIDTH-1:0] r_op_b;
   logic [WIDTH-1:0] r_res;
   logic [CNT_W-1:0] r_count;
   logic             r_carry;
   logic             r_cin_msb;
   logic             w_sum;
   logic             w_cout;

   full_adder_1b u_fa (
      .A  (r_op_a[0]),
      .B  (r_op_b[0]),
      .CI (r_carry),
      .S  (w_sum),
      .CO (w_cout)
   );

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_state   <= SAS_IDLE;
         r_op_a    <= '0;
         r_op_b    <= '0;
         r_res     <= '0;
         r_count   <= '0;
         r_carry   <= 1'b0;
         r_cin_msb <= 1'b0;
         Y         <= '0;
         CO        <= 1'b0;
         V         <= 1'b0;
         Z         <= 1'b1;
         BUSY      <= 1'b0;
         DONE      <= 1'b0;
      end else begin
         DONE <= 1'b0;
         case (r_state)
            SAS_IDLE: begin
               if (START) begin
                  // Subtraction is A + ~B + 1: invert B and seed the carry with 1.
                  r_op_a  <= A;
                  r_op_b  <= SUB ? ~B : B;
                  r_carry <= SUB;
                  r_count <= '0;
                  BUSY    <= 1'b1;
                  r_state <= SAS_RUN;
               end
            end
            SAS_RUN: begin
               r_res   <= {w_sum, r_res[WIDTH-1:1]};
               r_op_a  <= r_op_a >> 1;
               r_op_b  <= r_op_b >> 1;
               r_carry <= w_cout;
               if (r_count == CNT_W'(WIDTH - 1)) begin
                  // Carry into the MSB is kept for the signed-overflow flag.
                  r_cin_msb <= r_carry;
                  BUSY      <= 1'b0;
                  r_state   <= SAS_FINISH;
               end else begin
                  r_count <= r_count + 1'b1;
               end
            end
            SAS_FINISH: begin
               Y       <= r_res;
               CO      <= r_carry;
               V       <= r_cin_msb ^ r_carry;
               Z       <= (r_res == '0);
               DONE    <= 1'b1;
               r_state <= SAS_IDLE;
            end
            default: r_state <= SAS_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_add_sub.sv
// Directed bench for serial_add_sub: vector table plus protocol, back-to-back and reset corners.
module tb_serial_add_sub;

   logic        CLK;
   logic        RST;
   logic        START;
   logic        SUB;
   logic [31:0] A;
   logic [31:0] B;
   logic [31:0] Y;
   logic        CO;
   logic        V;
   logic        Z;
   logic        BUSY;
   logic        DONE;

   int n_checks = 0;
   int n_fail   = 0;

   serial_add_sub #(.WIDTH(32), .CNT_W(6)) dut (
      .CLK   (CLK),
      .RST   (RST),
      .START (START),
      .SUB   (SUB),
      .A     (A),
      .B     (B),
      .Y     (Y),
      .CO    (CO),
      .V     (V),
      .Z     (Z),
      .BUSY  (BUSY),
      .DONE  (DONE)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      string       name;
      logic [31:0] a;
      logic [31:0] b;
      logic        sub;
      logic [31:0] y;
      logic        co;
      logic        v;
      logic        z;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Launches one operation and waits (bounded) for DONE; operands are scrambled after sampling.
   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sub,
                         output int lat, output int busy_n);
      logic [31:0] y_before;
      @(negedge CLK);
      y_before = Y;
      A = a; B = b; SUB = sub; START = 1'b1;
      @(negedge CLK);
      START = 1'b0;
      A = $urandom; B = $urandom; SUB = ~sub;
      lat = 0;
      busy_n = 0;
      while (!DONE && lat < 100) begin
         if (BUSY) busy_n++;
         if (lat == 16) check("y_holds_while_busy", Y, y_before);
         @(negedge CLK);
         lat++;
      end
   endtask

   vec_t vecs[$];
   int   lat;
   int   busy_n;
   int   gap;
   int   pulses;

   initial begin
      vecs.push_back('{"add_5_3",      32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0008, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{"add_carry_z",  32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1});
      vecs.push_back('{"add_ovf",      32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0});
      vecs.push_back('{"sub_ovf",      32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0});
      vecs.push_back('{"sub_borrow",   32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{"sub_equal",    32'h0000_0007, 32'h0000_0007, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1});
      vecs.push_back('{"sub_zero",     32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1});
      vecs.push_back('{"add_min_min",  32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1});
      vecs.push_back('{"add_mixed",    32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 32'hACF1_3568, 1'b0, 1'b0, 1'b0});

      RST = 1'b0; START = 1'b0; SUB = 1'b0; A = '0; B = '0;
      #12;
      check("rst_y",    Y,    32'h0);
      check("rst_co",   32'(CO),   32'h0);
      check("rst_v",    32'(V),    32'h0);
      check("rst_z",    32'(Z),    32'h1);
      check("rst_busy", 32'(BUSY), 32'h0);
      check("rst_done", 32'(DONE), 32'h0);
      @(negedge CLK);
      RST = 1'b1;

      foreach (vecs[i]) begin
         run_op(vecs[i].a, vecs[i].b, vecs[i].sub, lat, busy_n);
         check({vecs[i].name, "_latency"}, 32'(lat), 32'd33);
         check({vecs[i].name, "_busy_cycles"}, 32'(busy_n), 32'd32);
         check({vecs[i].name, "_y"},  Y,       vecs[i].y);
         check({vecs[i].name, "_co"}, 32'(CO), 32'(vecs[i].co));
         check({vecs[i].name, "_v"},  32'(V),  32'(vecs[i].v));
         check({vecs[i].name, "_z"},  32'(Z),  32'(vecs[i].z));
      end

      // START re-asserted at cycle 10 of a run with different operands must be ignored.
      @(negedge CLK);
      A = 32'd5; B = 32'd3; SUB = 1'b0; START = 1'b1;
      @(negedge CLK);
      START = 1'b0;
      lat = 0;
      while (!DONE && lat < 100) begin
         if (lat == 10) begin A = 32'd100; B = 32'd200; SUB = 1'b1; START = 1'b1; end
         if (lat == 11) START = 1'b0;
         @(negedge CLK);
         lat++;
      end
      check("ignore_start_latency", 32'(lat), 32'd33);
      check("ignore_start_y", Y, 32'h0000_0008);
      pulses = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge CLK);
         if (DONE || BUSY) pulses++;
      end
      check("ignore_start_no_second_op", 32'(pulses), 32'd0);

      // START raised in the DONE cycle: second DONE lands exactly 34 cycles later.
      run_op(32'd1, 32'd2, 1'b0, lat, busy_n);
      check("b2b_first_y", Y, 32'h0000_0003);
      A = 32'd10; B = 32'd20; SUB = 1'b1; START = 1'b1;
      @(negedge CLK);
      START = 1'b0;
      gap = 1;
      while (!DONE && gap < 100) begin
         @(negedge CLK);
         gap++;
      end
      check("b2b_gap", 32'(gap), 32'd34);
      check("b2b_second_y",  Y,       32'hFFFF_FFF6);
      check("b2b_second_co", 32'(CO), 32'h0);
      check("b2b_second_v",  32'(V),  32'h0);

      // Reset at cycle 15 of a run aborts it immediately.
      @(negedge CLK);
      A = 32'h0000_1234; B = 32'd1; SUB = 1'b0; START = 1'b1;
      @(negedge CLK);
      START = 1'b0;
      for (int c = 0; c < 15; c++) @(negedge CLK);
      check("midrst_busy_before", 32'(BUSY), 32'h1);
      RST = 1'b0;
      #1;
      check("midrst_y",    Y,         32'h0);
      check("midrst_z",    32'(Z),    32'h1);
      check("midrst_busy", 32'(BUSY), 32'h0);
      pulses = 0;
      for (int c = 0; c < 3; c++) begin
         @(negedge CLK);
         if (DONE) pulses++;
      end
      RST = 1'b1;
      for (int c = 0; c < 40; c++) begin
         @(negedge CLK);
         if (DONE) pulses++;
      end
      check("midrst_no_done", 32'(pulses), 32'd0);
      run_op(32'd2, 32'd2, 1'b0, lat, busy_n);
      check("after_rst_latency", 32'(lat), 32'd33);
      check("after_rst_y", Y,      32'h0000_0004);
      check("after_rst_z", 32'(Z), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/serial_add_sub.md
Name: serial_add_sub

Overview:
- Bit-serial adder/subtractor. Computes Y = A + B or Y = A - B, one bit per clock, LSB first, through a single one-bit full-adder cell and a carry flip-flop.
- Serves as the area-minimal arithmetic path in the ALU sandbox and is the sequential counterpart of the combinational adder chain.
- Start/done handshake. Flags: carry out, overflow, zero.

Parameters:
WIDTH, 32, operand/result width; must equal `DATA_WIDTH from prj_definition.v in the project build
CNT_W, 6, bit-counter width; must satisfy 2**CNT_W > WIDTH

Ports:
CLK  input  1  system clock; all state updates on posedge
RST  input  1  asynchronous active-low reset; negedge RST clears all state immediately
START  input  1  request; sampled only in IDLE
SUB  input  1  0 = add, 1 = subtract; sampled with START
A  input  WIDTH  operand A; sampled with START
B  input  WIDTH  operand B; sampled with START
Y  output  WIDTH  result; holds last completed value
CO  output  1  final carry out (subtract: 1 = no borrow)
V  output  1  signed overflow
Z  output  1  1 when Y == 0
BUSY  output  1  high in RUN state
DONE  output  1  one-cycle pulse when Y/CO/V/Z become valid

Behaviour:
- Reset (RST low, asynchronous):
  - state = IDLE
  - Y = 0, CO = 0, V = 0, Z = 1, BUSY = 0, DONE = 0
  - internal operand shift registers, carry and counter = 0
- States: IDLE, RUN, FINISH.
- IDLE:
  - START = 1 at a posedge loads opA = A, opB = SUB ? ~B : B, carry = SUB, count = 0, state -> RUN.
  - START = 0 stays in IDLE; outputs hold.
- RUN, every posedge:
  - s = opA[0] ^ opB[0] ^ carry; cout = majority(opA[0], opB[0], carry)
  - result shift register shifts right, s inserted at MSB; opA and opB shift right, 0 inserted
  - carry = cout
  - When count == WIDTH-1: save carry-in of this bit as cin_msb, state -> FINISH.
  - Otherwise count increments.
- FINISH, one cycle:
  - Y = result, CO = carry, V = cin_msb ^ carry, Z = (result == 0)
  - DONE = 1 for exactly this edge's cycle; state -> IDLE
- Outputs Y/CO/V/Z change only on the FINISH edge (or reset). They are never partially updated while BUSY.
- Latency: START sampled at edge k gives DONE high after edge k+WIDTH+1, i.e. 33 cycles for WIDTH = 32.
- START while BUSY or in FINISH is ignored; no queuing.
- Back-to-back: START may be asserted in the same cycle DONE is high. It is sampled in IDLE at the next edge.
- A, B, SUB may change freely after sampling without affecting the operation in flight.
- Reset mid-operation aborts immediately. No DONE pulse; outputs take reset values.
- Subtraction is two's complement (A + ~B + 1). CO = 1 means A >= B unsigned.
- Width rule: all arithmetic is modulo 2**WIDTH. There is no sign extension and no saturation.

Decomposition:
- `DATA_WIDTH / `DATA_INDEX_LIMIT come from prj_definition.v.
- State encodings IDLE = 2'b00, RUN = 2'b01, FINISH = 2'b10 are added there as `SAS_IDLE/`SAS_RUN/`SAS_FINISH.
- One sub-module: full_adder_1b, a combinational one-bit full adder (S, CO from A, B, CI), instantiated once.
- The control FSM, counter and shift registers stay in the top module.

Test Plan:
- Add: A=5, B=3, SUB=0, START 1 cycle -> DONE after 33 cycles, Y=0x00000008, CO=0, V=0, Z=0; BUSY high for exactly 32 cycles.
- Carry/zero: A=0xFFFFFFFF, B=1, add -> Y=0x00000000, CO=1, V=0, Z=1.
- Signed overflow: A=0x7FFFFFFF, B=1, add -> Y=0x80000000, CO=0, V=1. Then A=0x80000000, B=1, sub -> Y=0x7FFFFFFF, CO=1, V=1.
- Borrow: A=5, B=7, sub -> Y=0xFFFFFFFE, CO=0, V=0, Z=0. Then A=7, B=7, sub -> Y=0, CO=1, Z=1.
- Protocol:
  - START pulsed again at cycle 10 of a run, with different A/B -> ignored; first result unchanged.
  - START asserted during the DONE cycle -> second result DONE exactly 34 cycles after the first.
- Reset mid-op: RST low at cycle 15 of a run -> immediately Y=0, Z=1, BUSY=0, no DONE pulse. After release, a new op A=2, B=2 gives Y=4.
